// File: rtl/phase_pkg.sv
// rtl/phase_pkg.sv - shared constants and types for the phase sequencer
//
// Holds the opcode values, the select codes that the register selector decodes
// for each step, the phase state enum, and the decode result struct.
package phase_pkg;

  // Opcodes recognised by the decoder.
  localparam logic [7:0] OP_PUSH_EBP = 8'h55;
  localparam logic [7:0] OP_POP_EBP  = 8'h5D;
  localparam logic [7:0] OP_MOV      = 8'h89;
  localparam logic [7:0] OP_RET      = 8'hC3;
  localparam logic [7:0] OP_CALL     = 8'hE8;
  localparam logic [7:0] OP_NOP      = 8'h90;

  // Select code that routes nothing. Used for every step past the step count.
  localparam logic [3:0] SEL_ZERO      = 4'd0;

  // Step 1 select codes.
  localparam logic [3:0] SEL1_PUSH_EBP = 4'd5;
  localparam logic [3:0] SEL1_POP_EBP  = 4'd4;
  localparam logic [3:0] SEL1_MOV      = 4'd2;
  localparam logic [3:0] SEL1_RET      = 4'd4;
  localparam logic [3:0] SEL1_CALL     = 4'd7;
  localparam logic [3:0] SEL1_NOP      = 4'd1;

  // Step 2 select code; every multi-step opcode touches the stack pointer here.
  localparam logic [3:0] SEL2_STACK    = 4'd2;

  // Step 3 select codes.
  localparam logic [3:0] SEL3_RET      = 4'd1;
  localparam logic [3:0] SEL3_CALL     = 4'd2;

  // IDLE followed by the seven execution phases. Odd phases read, even
  // phases from P4 upward write back.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P2   = 3'd1,
    P3   = 3'd2,
    P4   = 3'd3,
    P5   = 3'd4,
    P6   = 3'd5,
    P7   = 3'd6,
    P8   = 3'd7
  } phase_t;

  typedef struct packed {
    logic [1:0] steps;
    logic [3:0] sel1;
    logic [3:0] sel2;
    logic [3:0] sel3;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - combinational opcode to step-count and select-code decoder
//
// Ports:
//   opcode   in   8  instruction byte
//   dec      out     {steps, sel1, sel2, sel3, illegal}
// Parameter:
//   ILLEGAL_SEL      step 1 select code for an undecodable opcode
module op_decode
  import phase_pkg::*;
#(
  parameter logic [3:0] ILLEGAL_SEL = 4'h1
) (
  input  logic [7:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec.steps   = 2'd1;
    dec.sel1    = ILLEGAL_SEL;
    dec.sel2    = SEL_ZERO;
    dec.sel3    = SEL_ZERO;
    dec.illegal = 1'b0;
    case (opcode)
      OP_PUSH_EBP: begin dec.steps = 2'd2; dec.sel1 = SEL1_PUSH_EBP; dec.sel2 = SEL2_STACK; end
      OP_POP_EBP:  begin dec.steps = 2'd2; dec.sel1 = SEL1_POP_EBP;  dec.sel2 = SEL2_STACK; end
      OP_MOV:      begin dec.steps = 2'd1; dec.sel1 = SEL1_MOV; end
      OP_RET:      begin dec.steps = 2'd3; dec.sel1 = SEL1_RET;  dec.sel2 = SEL2_STACK; dec.sel3 = SEL3_RET; end
      OP_CALL:     begin dec.steps = 2'd3; dec.sel1 = SEL1_CALL; dec.sel2 = SEL2_STACK; dec.sel3 = SEL3_CALL; end
      OP_NOP:      begin dec.steps = 2'd1; dec.sel1 = SEL1_NOP; end
      default:     dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - accepts opcodes and sequences selector read/write-back phases
//
// Ports:
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   opcode, op_valid, op_ready       opcode handshake; ready only in IDLE
//   stall                            freezes the phase counter
//   select_1, select_2, select_3     registered select codes, loaded on accept
//   clock_3, clock_5, clock_7        read-step strobes (phases P3, P5, P7)
//   wb_strobe                        write-back enable, once per executed step
//   busy                             sequence in progress
//   done                             pulse on the final write-back
//   illegal                          pulse in P2 for an undecodable opcode
module phase_sequencer
  import phase_pkg::*;
#(
  parameter logic [3:0] ILLEGAL_SEL = 4'h1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       stall,
  output logic [3:0] select_1,
  output logic [3:0] select_2,
  output logic [3:0] select_3,
  output logic       clock_3,
  output logic       clock_5,
  output logic       clock_7,
  output logic       wb_strobe,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  phase_t  state;
  phase_t  state_next;
  phase_t  last_phase;
  logic    illegal_q;
  logic    accept;
  decode_t dec;

  op_decode #(.ILLEGAL_SEL(ILLEGAL_SEL)) u_op_decode (
    .opcode (opcode),
    .dec    (dec)
  );

  assign accept = op_valid && (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Decode results are captured once at accept so the opcode bus is free
  // for fetch for the rest of the sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      select_1   <= SEL_ZERO;
      select_2   <= SEL_ZERO;
      select_3   <= SEL_ZERO;
      illegal_q  <= 1'b0;
      last_phase <= P4;
    end else if (accept) begin
      select_1  <= dec.sel1;
      select_2  <= dec.sel2;
      select_3  <= dec.sel3;
      illegal_q <= dec.illegal;
      case (dec.steps)
        2'd2:    last_phase <= P6;
        2'd3:    last_phase <= P8;
        default: last_phase <= P4;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    op_ready   = 1'b0;
    clock_3    = 1'b0;
    clock_5    = 1'b0;
    clock_7    = 1'b0;
    wb_strobe  = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_next = P2;
      end
      P2: if (!stall) state_next = P3;
      P3: begin
        clock_3 = 1'b1;
        if (!stall) state_next = P4;
      end
      P4: begin
        // Write-back only on the cycle the phase advances, so a stall
        // cannot repeat the write.
        wb_strobe = !stall;
        if (!stall) state_next = (last_phase == P4) ? IDLE : P5;
      end
      P5: begin
        clock_5 = 1'b1;
        if (!stall) state_next = P6;
      end
      P6: begin
        wb_strobe = !stall;
        if (!stall) state_next = (last_phase == P6) ? IDLE : P7;
      end
      P7: begin
        clock_7 = 1'b1;
        if (!stall) state_next = P8;
      end
      P8: begin
        wb_strobe = !stall;
        if (!stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = wb_strobe && (state == last_phase);
  assign illegal = illegal_q && (state == P2);

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer
module tb_phase_sequencer;

  logic       clock;
  logic       reset;
  logic [7:0] opcode;
  logic       op_valid;
  logic       op_ready;
  logic       stall;
  logic [3:0] select_1, select_2, select_3;
  logic       clock_3, clock_5, clock_7;
  logic       wb_strobe, busy, done, illegal;

  int vectors;
  int miscompares;

  // Reference model: phase number 0 (idle) or 2..8, last write-back phase
  // is 2*steps+2, plus the selects captured at accept.
  int         m_phase;
  int         m_last;
  logic [3:0] m_s1, m_s2, m_s3;
  logic       m_ill;

  localparam logic [19:0] RESET_OUTS = 20'h80000;

  phase_sequencer #(.ILLEGAL_SEL(4'h1)) dut (
    .clock     (clock),
    .reset     (reset),
    .opcode    (opcode),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .stall     (stall),
    .select_1  (select_1),
    .select_2  (select_2),
    .select_3  (select_3),
    .clock_3   (clock_3),
    .clock_5   (clock_5),
    .clock_7   (clock_7),
    .wb_strobe (wb_strobe),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
  );

  always #5 clock = ~clock;

  // {illegal, steps, sel1, sel2, sel3} from the decode table.
  function automatic logic [14:0] ref_decode(input logic [7:0] op);
    case (op)
      8'h55:   return {1'b0, 2'd2, 4'd5, 4'd2, 4'd0};
      8'h5D:   return {1'b0, 2'd2, 4'd4, 4'd2, 4'd0};
      8'h89:   return {1'b0, 2'd1, 4'd2, 4'd0, 4'd0};
      8'hC3:   return {1'b0, 2'd3, 4'd4, 4'd2, 4'd1};
      8'hE8:   return {1'b0, 2'd3, 4'd7, 4'd2, 4'd2};
      8'h90:   return {1'b0, 2'd1, 4'd1, 4'd0, 4'd0};
      default: return {1'b1, 2'd1, 4'd1, 4'd0, 4'd0};
    endcase
  endfunction

  function automatic logic [19:0] dut_outs();
    return {op_ready, busy, clock_3, clock_5, clock_7, wb_strobe, done, illegal,
            select_1, select_2, select_3};
  endfunction

  function automatic logic [19:0] exp_outs();
    logic wb;
    wb = (m_phase == 4 || m_phase == 6 || m_phase == 8) && !stall;
    return {m_phase == 0, m_phase != 0, m_phase == 3, m_phase == 5, m_phase == 7,
            wb, wb && (m_phase == m_last), m_ill && (m_phase == 2), m_s1, m_s2, m_s3};
  endfunction

  task automatic model_update();
    logic [14:0] d;
    if (reset) begin
      m_phase = 0; m_last = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0; m_ill = 0;
    end else if (m_phase == 0) begin
      if (op_valid) begin
        d = ref_decode(opcode);
        m_ill = d[14];
        m_last = 2 * int'(d[13:12]) + 2;
        m_s1 = d[11:8]; m_s2 = d[7:4]; m_s3 = d[3:0];
        m_phase = 2;
      end
    end else if (!stall) begin
      m_phase = (m_phase == m_last) ? 0 : m_phase + 1;
    end
  endtask

  task automatic apply(input logic v, input logic [7:0] op, input logic st, input logic rst);
    reset = rst; op_valid = v; opcode = op; stall = st;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic test_reset();
    apply(0, 8'h00, 0, 1); tick(); tick();
    apply(0, 8'h00, 0, 0);
    vectors++;
    if (dut_outs() !== RESET_OUTS) begin
      miscompares++; $display("FAIL reset_state got=%h exp=%h", dut_outs(), RESET_OUTS);
    end
    vectors++;
    if (dut_outs() !== exp_outs()) begin
      miscompares++; $display("FAIL reset_model got=%h exp=%h", dut_outs(), exp_outs());
    end
  endtask

  task automatic test_push();
    int done_cyc = -1, c3_cyc = -1, wb_cnt = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) apply(1, 8'h55, 0, 0); else apply(0, 8'h00, 0, 0);
      vectors++;
      if (dut_outs() !== exp_outs()) begin
        miscompares++; $display("FAIL push_cyc%0d got=%h exp=%h", c, dut_outs(), exp_outs());
      end
      if (done) done_cyc = c;
      if (clock_3) c3_cyc = c;
      if (wb_strobe) wb_cnt++;
      if (c == 1) begin
        vectors++;
        if ({select_1, select_2} !== 8'h52) begin
          miscompares++; $display("FAIL push_sel got=%h exp=52", {select_1, select_2});
        end
      end
      if (c == 6) begin
        vectors++;
        if (op_ready !== 1'b1) begin
          miscompares++; $display("FAIL push_ready_t6 got=%b exp=1", op_ready);
        end
      end
      tick();
    end
    vectors++;
    if (done_cyc != 5 || c3_cyc != 2 || wb_cnt != 2) begin
      miscompares++;
      $display("FAIL push_timing got done=%0d c3=%0d wb=%0d exp done=5 c3=2 wb=2", done_cyc, c3_cyc, wb_cnt);
    end
  endtask

  task automatic test_ret_stall();
    int done_cyc = -1, c5_cnt = 0, wb_cnt = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) apply(1, 8'hC3, 0, 0);
      else apply(0, 8'h00, (c == 4 || c == 5), 0);
      vectors++;
      if (dut_outs() !== exp_outs()) begin
        miscompares++; $display("FAIL ret_stall_cyc%0d got=%h exp=%h", c, dut_outs(), exp_outs());
      end
      if (done) done_cyc = c;
      if (clock_5) c5_cnt++;
      if (wb_strobe) wb_cnt++;
      tick();
    end
    vectors++;
    if (done_cyc != 9 || c5_cnt != 3 || wb_cnt != 3) begin
      miscompares++;
      $display("FAIL ret_stall_timing got done=%0d c5=%0d wb=%0d exp done=9 c5=3 wb=3", done_cyc, c5_cnt, wb_cnt);
    end
  endtask

  task automatic test_mov();
    int done_cyc = -1, c57 = 0;
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) apply(1, 8'h89, 0, 0); else apply(0, 8'h00, 0, 0);
      vectors++;
      if (dut_outs() !== exp_outs()) begin
        miscompares++; $display("FAIL mov_cyc%0d got=%h exp=%h", c, dut_outs(), exp_outs());
      end
      if (done) done_cyc = c;
      if (clock_5 || clock_7) c57++;
      if (c == 1) begin
        vectors++;
        if ({select_1, select_2, select_3} !== 12'h200) begin
          miscompares++; $display("FAIL mov_sel got=%h exp=200", {select_1, select_2, select_3});
        end
      end
      tick();
    end
    vectors++;
    if (done_cyc != 3 || c57 != 0) begin
      miscompares++; $display("FAIL mov_timing got done=%0d c5c7=%0d exp done=3 c5c7=0", done_cyc, c57);
    end
  endtask

  task automatic test_illegal();
    int done_cyc = -1, ill_cyc = -1;
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) apply(1, 8'hFF, 0, 0); else apply(0, 8'h00, 0, 0);
      vectors++;
      if (dut_outs() !== exp_outs()) begin
        miscompares++; $display("FAIL illegal_cyc%0d got=%h exp=%h", c, dut_outs(), exp_outs());
      end
      if (done) done_cyc = c;
      if (illegal) ill_cyc = c;
      if (c == 1) begin
        vectors++;
        if (select_1 !== 4'h1) begin
          miscompares++; $display("FAIL illegal_sel got=%h exp=1", select_1);
        end
      end
      tick();
    end
    vectors++;
    if (done_cyc != 3 || ill_cyc != 1) begin
      miscompares++; $display("FAIL illegal_timing got done=%0d ill=%0d exp done=3 ill=1", done_cyc, ill_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int nxt = 0, accepts = 0, dones = 0, exp_accepts = 0;
    logic [7:0] op;
    for (int c = 0; c < 48; c++) begin
      logic acc;
      acc = (m_phase == 0);
      op = acc ? (nxt == 0 ? 8'hE8 : 8'h90) : 8'($urandom);
      apply(1, op, 0, 0);
      vectors++;
      if (dut_outs() !== exp_outs()) begin
        miscompares++; $display("FAIL b2b_cyc%0d got=%h exp=%h", c, dut_outs(), exp_outs());
      end
      if (op_ready) accepts++;
      if (done) dones++;
      if (acc) begin exp_accepts++; nxt ^= 1; end
      tick();
    end
    // 48 cycles at 8 + 4 cycles per pair of instructions: exactly 8 accepts.
    vectors++;
    if (accepts != exp_accepts || exp_accepts != 8 || dones != 8) begin
      miscompares++;
      $display("FAIL b2b_counts got acc=%0d done=%0d exp acc=8 done=8", accepts, dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) apply(1, 8'hE8, 0, 0); else apply(0, 8'h00, 0, c == 4);
      vectors++;
      if (dut_outs() !== exp_outs()) begin
        miscompares++; $display("FAIL rstmid_cyc%0d got=%h exp=%h", c, dut_outs(), exp_outs());
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      apply(0, 8'h00, 0, 0);
      vectors++;
      if (dut_outs() !== RESET_OUTS) begin
        miscompares++; $display("FAIL rstmid_after%0d got=%h exp=%h", c, dut_outs(), RESET_OUTS);
      end
      if (done) dones++;
      tick();
    end
    vectors++;
    if (dones != 0) begin
      miscompares++; $display("FAIL rstmid_done got=%0d exp=0", dones);
    end
    // Reset coincident with an accept: reset wins.
    apply(1, 8'h55, 0, 1); tick();
    apply(0, 8'h00, 0, 0);
    vectors++;
    if (dut_outs() !== RESET_OUTS) begin
      miscompares++; $display("FAIL rst_vs_accept got=%h exp=%h", dut_outs(), RESET_OUTS);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [7];
    ops[0] = 8'h55; ops[1] = 8'h5D; ops[2] = 8'h89; ops[3] = 8'hC3;
    ops[4] = 8'hE8; ops[5] = 8'h90; ops[6] = 8'h00;
    for (int c = 0; c < 600; c++) begin
      int k;
      logic [7:0] op;
      k = int'($urandom_range(0, 7));
      op = (k < 7) ? ops[k] : 8'($urandom);
      apply($urandom_range(0, 2) != 0, op, $urandom_range(0, 3) == 0,
            $urandom_range(0, 49) == 0);
      vectors++;
      if (dut_outs() !== exp_outs()) begin
        miscompares++; $display("FAIL random_cyc%0d got=%h exp=%h", c, dut_outs(), exp_outs());
      end
      tick();
    end
  endtask

  initial begin
    clock = 0; reset = 1; opcode = 0; op_valid = 0; stall = 0;
    vectors = 0; miscompares = 0;
    m_phase = 0; m_last = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0; m_ill = 0;
    test_reset();
    test_push();
    test_ret_stall();
    test_mov();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
